// File: rtl/cdc_hs_feeder.sv
// ---------------------------------------------------------------------------
// cdc_hs_feeder
//
// Source-side feeder for a handshake CDC byte channel (xpm_cdc_handshake with
// DEST_EXT_HSK=0). A producer without backpressure fires single-cycle byte
// strobes. Bytes are queued in a FIFO and handed to the CDC one at a time
// using the full src_send / src_rcv four-phase protocol. A byte that arrives
// while the FIFO is full is dropped and counted.
//
// Ports
//   aclk      in   source-domain clock
//   aresetn   in   asynchronous active-low reset
//   in_data   in   producer byte, valid only while in_valid is high
//   in_valid  in   single-cycle producer strobe
//   src_in    out  byte presented to the CDC, held for the whole transfer
//   src_send  out  CDC request, registered, high exactly while in SEND
//   src_rcv   in   CDC acknowledge
//   level     out  FIFO occupancy 0..DEPTH (excludes the holding register)
//   busy      out  FSM not IDLE, or FIFO not empty
//   overflow  out  one-cycle pulse after a dropped strobe
//   drop_cnt  out  saturating count of dropped bytes
// ---------------------------------------------------------------------------
module cdc_hs_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] src_in,
  output logic             src_send,
  input  logic             src_rcv,
  output logic [LW-1:0]    level,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // WAIT_LOW is the reset state so that an acknowledge left high by a transfer
  // interrupted by reset can never terminate the next transfer.
  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    SEND     = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] hold_q;

  logic             pop;
  logic             push;
  logic             drop;
  logic [LW-1:0]    level_next;

  // Pop only from IDLE; a push into an empty FIFO therefore never falls
  // through to the holding register in the same cycle.
  assign pop  = (state == IDLE) && (level != '0);
  // A full FIFO can still accept a strobe when a pop frees a slot this cycle.
  assign push = in_valid && ((level != FULL_LEVEL) || pop);
  assign drop = in_valid && !push;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // NOTE: the storage array has no reset; its contents are only ever read
  // behind a nonzero level, and leaving it unreset lets it map to RAM.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
    end
  end

  // Drop accounting: overflow and drop_cnt move on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= drop;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Handshake FSM with registered src_send, hold_q and busy. busy is loaded
  // with the value that matches the state and level being entered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= WAIT_LOW;
      src_send <= 1'b0;
      hold_q   <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        WAIT_LOW: begin
          src_send <= 1'b0;
          if (!src_rcv) begin
            state <= IDLE;
            busy  <= (level_next != '0);
          end else begin
            busy  <= 1'b1;
          end
        end
        IDLE: begin
          if (pop) begin
            hold_q   <= mem[rd_ptr];
            state    <= SEND;
            src_send <= 1'b1;
            busy     <= 1'b1;
          end else begin
            src_send <= 1'b0;
            busy     <= (level_next != '0);
          end
        end
        SEND: begin
          busy <= 1'b1;
          if (src_rcv) begin
            state    <= WAIT_LOW;
            src_send <= 1'b0;
          end else begin
            src_send <= 1'b1;
          end
        end
        default: begin
          state    <= WAIT_LOW;
          src_send <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

  assign src_in = hold_q;

endmodule

// File: tb/tb_cdc_hs_feeder.sv
// ---------------------------------------------------------------------------
// tb_cdc_hs_feeder
//
// Directed bench for cdc_hs_feeder. A small CDC responder (running on the
// falling edge) acknowledges a request after ack_dly cycles and releases
// after rel_dly cycles, logging each byte it receives. Scenario tasks can
// instead drive src_rcv by hand. Inputs are driven and outputs observed 1 ns
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_cdc_hs_feeder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] src_in;
  logic             src_send;
  logic             src_rcv;
  logic [LW-1:0]    level;
  logic             busy;
  logic             overflow;
  logic [7:0]       drop_cnt;

  // CDC responder controls; src_rcv comes from the responder or the test.
  logic             cdc_auto = 1'b0;
  logic             model_rcv = 1'b0;
  logic             man_rcv = 1'b0;
  int               ack_dly = 6;
  int               rel_dly = 6;
  int               mcnt = 0;
  logic [7:0]       rx_q [$];

  int               n_checks = 0;
  int               n_fail = 0;

  assign src_rcv = cdc_auto ? model_rcv : man_rcv;

  always #5 aclk = ~aclk;

  cdc_hs_feeder #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .src_in   (src_in),
    .src_send (src_send),
    .src_rcv  (src_rcv),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial begin : cdc_model
    forever begin
      @(negedge aclk);
      if (!cdc_auto) begin
        mcnt      = 0;
        model_rcv = 1'b0;
      end else if (src_send && !model_rcv) begin
        if (mcnt == 0) rx_q.push_back(src_in);
        mcnt++;
        if (mcnt >= ack_dly) begin
          model_rcv = 1'b1;
          mcnt      = 0;
        end
      end else if (!src_send && model_rcv) begin
        mcnt++;
        if (mcnt >= rel_dly) begin
          model_rcv = 1'b0;
          mcnt      = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    cdc_auto = 1'b0;
    man_rcv  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    aresetn  = 1'b0;
    rx_q.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    cyc();
  endtask

  // Drive one strobe per cycle for n bytes starting at first.
  task automatic strobes(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      in_data  = first + 8'(i);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  // Wait until the responder has logged n bytes and the feeder is idle.
  task automatic drain(input int n, input string name);
    int t;
    t = 0;
    while (!(rx_q.size() >= n && busy === 1'b0 && src_rcv === 1'b0) && t < 5000) begin
      cyc();
      t++;
    end
    n_checks++;
    if (t >= 5000) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d bytes busy=%b required %0d bytes busy=0",
               name, rx_q.size(), busy, n);
    end
  endtask

  task automatic check_rx(input int n, input logic [7:0] first, input string name);
    n_checks++;
    if (rx_q.size() != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d required %0d", name, rx_q.size(), n);
    end
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== first + 8'(i)) begin
        n_fail++;
        $display("FAIL %s_byte%0d: got %h required %h", name, i, rx_q[i], first + 8'(i));
      end
    end
  endtask

  task automatic test_reset();
    cdc_auto = 1'b0;
    man_rcv  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    aresetn  = 1'b0;
    #12;
    n_checks++;
    if ({src_send, src_in, level, busy, overflow, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got send=%b in=%h level=%0d busy=%b ovf=%b drops=%0d required all 0",
               src_send, src_in, level, busy, overflow, drop_cnt);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if ({src_send, level, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got send=%b level=%0d busy=%b required 0 0 0",
               src_send, level, busy);
    end
  endtask

  task automatic test_single_byte();
    int t;
    do_reset();
    ack_dly  = 6;
    rel_dly  = 6;
    cdc_auto = 1'b1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (level !== LW'(1) || src_send !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after_strobe: got level=%0d send=%b required level=1 send=0", level, src_send);
    end
    cyc();
    n_checks++;
    if (src_send !== 1'b1 || src_in !== 8'hA5 || level !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_send_rise: got send=%b in=%h level=%0d busy=%b required 1 a5 0 1",
               src_send, src_in, level, busy);
    end
    t = 0;
    while (src_rcv !== 1'b1 && t < 100) begin
      n_checks++;
      if (src_send !== 1'b1 || src_in !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_hold: got send=%b in=%h required 1 a5", src_send, src_in);
      end
      cyc();
      t++;
    end
    // src_rcv was sampled high at the edge just passed.
    n_checks++;
    if (t >= 100 || src_send !== 1'b0 || busy !== 1'b1 || src_in !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_send_fall: got send=%b busy=%b in=%h required 0 1 a5", src_send, busy, src_in);
    end
    t = 0;
    while (src_rcv !== 1'b0 && t < 100) begin
      cyc();
      t++;
    end
    n_checks++;
    if (t >= 100 || busy !== 1'b0 || src_send !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_end: got busy=%b send=%b required 0 0", busy, src_send);
    end
    check_rx(1, 8'hA5, "single");
  endtask

  task automatic test_back_to_back();
    int peak;
    int ovf_seen;
    do_reset();
    ack_dly  = 20;
    rel_dly  = 20;
    cdc_auto = 1'b1;
    peak     = 0;
    ovf_seen = 0;
    for (int i = 0; i < 16; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      cyc();
      if (int'(level) > peak) peak = int'(level);
      if (overflow === 1'b1) ovf_seen++;
    end
    in_valid = 1'b0;
    cyc();
    if (overflow === 1'b1) ovf_seen++;
    n_checks++;
    if (peak != 15) begin
      n_fail++;
      $display("FAIL burst_peak_level: got %0d required 15", peak);
    end
    drain(16, "burst");
    n_checks++;
    if (ovf_seen != 0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL burst_no_drop: got pulses=%0d drops=%0d required 0 0", ovf_seen, drop_cnt);
    end
    check_rx(16, 8'h00, "burst");
  endtask

  task automatic test_overflow();
    int ovf_seen;
    do_reset();
    ovf_seen = 0;
    for (int i = 0; i < 20; i++) begin
      in_data  = 8'h10 + 8'(i);
      in_valid = 1'b1;
      cyc();
      if (overflow === 1'b1) ovf_seen++;
      if (i == 16) begin
        n_checks++;
        if (level !== LW'(16) || overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_full: got level=%0d ovf=%b required 16 0", level, overflow);
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    if (overflow === 1'b1) ovf_seen++;
    n_checks++;
    if (ovf_seen != 3 || drop_cnt !== 8'd3 || level !== LW'(16)) begin
      n_fail++;
      $display("FAIL ovf_drops: got pulses=%0d drops=%0d level=%0d required 3 3 16",
               ovf_seen, drop_cnt, level);
    end
    n_checks++;
    if (src_send !== 1'b1 || src_in !== 8'h10) begin
      n_fail++;
      $display("FAIL ovf_hold: got send=%b in=%h required 1 10", src_send, src_in);
    end
    ack_dly  = 3;
    rel_dly  = 3;
    cdc_auto = 1'b1;
    drain(17, "ovf");
    check_rx(17, 8'h10, "ovf");
  endtask

  task automatic test_full_push_pop();
    do_reset();
    strobes(17, 8'h40);
    // Finish the in-flight transfer by hand so the IDLE pop lands on a known edge.
    man_rcv = 1'b1;
    cyc();
    man_rcv = 1'b0;
    cyc();
    n_checks++;
    if (level !== LW'(16) || src_send !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_pre: got level=%0d send=%b required 16 0", level, src_send);
    end
    in_data  = 8'h51;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (level !== LW'(16) || overflow !== 1'b0 || drop_cnt !== 8'd0 ||
        src_send !== 1'b1 || src_in !== 8'h41) begin
      n_fail++;
      $display("FAIL fullpp_same_cycle: got level=%0d ovf=%b drops=%0d send=%b in=%h required 16 0 0 1 41",
               level, overflow, drop_cnt, src_send, src_in);
    end
    ack_dly  = 3;
    rel_dly  = 3;
    cdc_auto = 1'b1;
    drain(17, "fullpp");
    check_rx(17, 8'h41, "fullpp");
  endtask

  task automatic test_reset_mid_transfer();
    int bad;
    do_reset();
    strobes(1, 8'h77);
    cyc();
    n_checks++;
    if (src_send !== 1'b1 || src_in !== 8'h77) begin
      n_fail++;
      $display("FAIL midrst_send: got send=%b in=%h required 1 77", src_send, src_in);
    end
    man_rcv = 1'b1;
    #3;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (src_send !== 1'b0 || src_in !== 8'h00 || level !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got send=%b in=%h level=%0d required 0 00 0", src_send, src_in, level);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    cyc();
    strobes(1, 8'h5A);
    n_checks++;
    if (level !== LW'(1) || src_send !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_push: got level=%0d send=%b required 1 0", level, src_send);
    end
    bad = 0;
    repeat (3) begin
      cyc();
      if (src_send !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrst_stale_ack: got %0d cycles with send=1 required 0", bad);
    end
    man_rcv = 1'b0;
    cyc();
    n_checks++;
    if (src_send !== 1'b0 || level !== LW'(1)) begin
      n_fail++;
      $display("FAIL midrst_rcv_low: got send=%b level=%0d required 0 1", src_send, level);
    end
    cyc();
    n_checks++;
    if (src_send !== 1'b1 || src_in !== 8'h5A || level !== '0) begin
      n_fail++;
      $display("FAIL midrst_resume: got send=%b in=%h level=%0d required 1 5a 0", src_send, src_in, level);
    end
  endtask

  task automatic test_drop_saturation();
    int missed;
    do_reset();
    strobes(17, 8'h80);
    missed = 0;
    for (int i = 0; i < 300; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      cyc();
      if (overflow !== 1'b1) missed++;
      if (i == 253) begin
        n_checks++;
        if (drop_cnt !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_254: got %0d required 254", drop_cnt);
        end
      end
      if (i == 254) begin
        n_checks++;
        if (drop_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL sat_255: got %0d required 255", drop_cnt);
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    n_checks++;
    if (missed != 0) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d missing pulses required 0", missed);
    end
    n_checks++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b0 || level !== LW'(16)) begin
      n_fail++;
      $display("FAIL sat_final: got drops=%0d ovf=%b level=%0d required 255 0 16",
               drop_cnt, overflow, level);
    end
  endtask

  initial begin : main
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_transfer();
    test_drop_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
